// File: rtl/pool_pkg.sv
// Shared types and width helpers for the max-pool streaming controller.
package pool_pkg;

    typedef enum logic {
        POOL_FWD = 1'b0,
        POOL_BWD = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_BWD  = 2'd2
    } state_e;

    localparam int DEF_STRIDE = 2;
    localparam int IDX_W      = $clog2(DEF_STRIDE * DEF_STRIDE);

    // Counter/index width that never collapses to zero bits for degenerate sizes.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_raster_cnt.sv
// Raster-order row/column walker over an IN_H x IN_W map, shared by the forward and backward passes.
module pool_raster_cnt
    import pool_pkg::*;
#(
    parameter int IN_W = 4,
    parameter int IN_H = 4,
    parameter int RW   = cnt_width(IN_H),
    parameter int CW   = cnt_width(IN_W)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [RW-1:0] r_o,
    output logic [RW-1:0] r_nxt_o,
    output logic [CW-1:0] c_o,
    output logic [CW-1:0] c_nxt_o,
    output logic          last_col_o,
    output logic          last_row_o,
    output logic          last_o
);

    logic [RW-1:0] r_q;
    logic [CW-1:0] c_q;
    logic [RW-1:0] r_d;
    logic [CW-1:0] c_d;

    // Wrap-around successor position, also exported so callers can look one step ahead.
    always_comb begin
        last_col_o = (c_q == CW'(IN_W - 1));
        last_row_o = (r_q == RW'(IN_H - 1));
        last_o     = last_col_o && last_row_o;
        if (last_col_o) begin
            c_d = '0;
            r_d = last_row_o ? '0 : (r_q + RW'(1));
        end else begin
            c_d = c_q + CW'(1);
            r_d = r_q;
        end
    end

    // Position register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_q <= '0;
            c_q <= '0;
        end else if (clr_i) begin
            r_q <= '0;
            c_q <= '0;
        end else if (adv_i) begin
            r_q <= r_d;
            c_q <= c_d;
        end else begin
            r_q <= r_q;
            c_q <= c_q;
        end
    end

    assign r_o     = r_q;
    assign c_o     = c_q;
    assign r_nxt_o = r_d;
    assign c_nxt_o = c_d;

endmodule

// File: rtl/max_pool_stream_ctrl.sv
// Streaming 2D max-pool sequencer: forward pooling with argmax capture, backward gradient routing.
module max_pool_stream_ctrl
    import pool_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STRIDE = 2,
    parameter int IN_W   = 4,
    parameter int IN_H   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    input  logic                    gin_valid,
    output logic                    gin_ready,
    input  logic signed [WIDTH-1:0] gin_data,
    output logic                    gout_valid,
    input  logic                    gout_ready,
    output logic signed [WIDTH-1:0] gout_data
);

    localparam int OUT_W = IN_W / STRIDE;
    localparam int OUT_H = IN_H / STRIDE;
    localparam int KN    = STRIDE * STRIDE;
    localparam int IDXW  = cnt_width(KN);
    localparam int RW    = cnt_width(IN_H);
    localparam int CW    = cnt_width(IN_W);
    localparam int OWW   = cnt_width(OUT_W);
    localparam int OHW   = cnt_width(OUT_H);

    generate
        if ((IN_W % STRIDE) != 0) begin : g_bad_w
            $error("IN_W must be a multiple of STRIDE");
        end
        if ((IN_H % STRIDE) != 0) begin : g_bad_h
            $error("IN_H must be a multiple of STRIDE");
        end
    endgenerate

    state_e state_q, state_d;

    logic [RW-1:0]   r_s, r_nxt_s;
    logic [CW-1:0]   c_s, c_nxt_s;
    logic            last_col_s, last_row_s, last_s;
    logic            cnt_clr_s, cnt_adv_s;

    logic signed [WIDTH-1:0] pbuf_q [OUT_W];
    logic [IDXW-1:0]         pidx_q [OUT_W];
    logic [IDXW-1:0]         idx_mem_q [OUT_H][OUT_W];
    logic signed [WIDTH-1:0] gbuf_q [OUT_W];
    logic [OWW-1:0]          gcnt_q;
    logic                    gload_q;
    logic                    out_valid_q, out_last_q, gout_valid_q, done_q;
    logic signed [WIDTH-1:0] out_data_q, gout_data_q;

    logic            busy_s, in_ready_s, gin_ready_s;
    logic            fwd_acc_s, out_acc_s, gin_acc_s, gout_acc_s;
    logic [OHW-1:0]  wr_s, swr_s;
    logic [OWW-1:0]  wc_s, swc_s;
    logic [IDXW-1:0] k_s, sk_s, max_idx_s;
    logic [RW-1:0]   sel_r_s;
    logic [CW-1:0]   sel_c_s;
    logic            win_last_s, load_done_s, band_end_s;
    logic signed [WIDTH-1:0] max_s, gsrc_s, groute_s;

    pool_raster_cnt #(
        .IN_W (IN_W),
        .IN_H (IN_H),
        .RW   (RW),
        .CW   (CW)
    ) u_cnt (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .clr_i      (cnt_clr_s),
        .adv_i      (cnt_adv_s),
        .r_o        (r_s),
        .r_nxt_o    (r_nxt_s),
        .c_o        (c_s),
        .c_nxt_o    (c_nxt_s),
        .last_col_o (last_col_s),
        .last_row_o (last_row_s),
        .last_o     (last_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a pass ends on the handshake of its final output word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (pool_mode_e'(mode) == POOL_BWD) ? S_BWD : S_FWD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FWD: begin
                if (out_acc_s && out_last_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FWD;
                end
            end
            S_BWD: begin
                if (gout_acc_s && band_end_s && last_row_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BWD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; a pending pooled word blocks further pixels.
    always_comb begin
        busy_s      = (state_q != S_IDLE);
        in_ready_s  = (state_q == S_FWD) && !(out_valid_q && !out_ready);
        gin_ready_s = (state_q == S_BWD) && gload_q;
    end

    // Window decode, running max, and backward routing of the word to present next.
    always_comb begin
        fwd_acc_s   = in_valid && in_ready_s;
        out_acc_s   = out_valid_q && out_ready;
        gin_acc_s   = gin_valid && gin_ready_s;
        gout_acc_s  = gout_valid_q && gout_ready;
        cnt_clr_s   = (state_q == S_IDLE);
        cnt_adv_s   = fwd_acc_s || gout_acc_s;

        wr_s        = OHW'(int'(r_s) / STRIDE);
        wc_s        = OWW'(int'(c_s) / STRIDE);
        k_s         = IDXW'((int'(r_s) % STRIDE) * STRIDE + (int'(c_s) % STRIDE));
        win_last_s  = (k_s == IDXW'(KN - 1));

        if (k_s == '0) begin
            max_s     = in_data;
            max_idx_s = '0;
        end else if (in_data > pbuf_q[wc_s]) begin
            max_s     = in_data;
            max_idx_s = k_s;
        end else begin
            max_s     = pbuf_q[wc_s];
            max_idx_s = pidx_q[wc_s];
        end

        load_done_s = gin_acc_s && (gcnt_q == OWW'(OUT_W - 1));
        band_end_s  = last_col_s && ((int'(r_s) % STRIDE) == (STRIDE - 1));

        sel_r_s     = gout_acc_s ? r_nxt_s : r_s;
        sel_c_s     = gout_acc_s ? c_nxt_s : c_s;
        swr_s       = OHW'(int'(sel_r_s) / STRIDE);
        swc_s       = OWW'(int'(sel_c_s) / STRIDE);
        sk_s        = IDXW'((int'(sel_r_s) % STRIDE) * STRIDE + (int'(sel_c_s) % STRIDE));
        // The first word of a band may need the gradient being written this very cycle.
        if (load_done_s && (swc_s == gcnt_q)) begin
            gsrc_s = gin_data;
        end else begin
            gsrc_s = gbuf_q[swc_s];
        end
        groute_s    = (idx_mem_q[swr_s][swc_s] == sk_s) ? gsrc_s : '0;
    end

    // Datapath registers for both directions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_W; i++) begin
                pbuf_q[i] <= '0;
                pidx_q[i] <= '0;
                gbuf_q[i] <= '0;
            end
            for (int i = 0; i < OUT_H; i++) begin
                for (int j = 0; j < OUT_W; j++) begin
                    idx_mem_q[i][j] <= '0;
                end
            end
            gcnt_q       <= '0;
            gload_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            gout_valid_q <= 1'b0;
            gout_data_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (out_acc_s) begin
                out_valid_q <= 1'b0;
                if (out_last_q && (state_q == S_FWD)) begin
                    done_q <= 1'b1;
                end
            end
            if (fwd_acc_s) begin
                pbuf_q[wc_s] <= max_s;
                pidx_q[wc_s] <= max_idx_s;
                if (win_last_s) begin
                    idx_mem_q[wr_s][wc_s] <= max_idx_s;
                    out_data_q            <= max_s;
                    out_valid_q           <= 1'b1;
                    out_last_q            <= last_s;
                end
            end

            if ((state_q == S_IDLE) && start && (pool_mode_e'(mode) == POOL_BWD)) begin
                gload_q <= 1'b1;
                gcnt_q  <= '0;
            end else if (gin_acc_s) begin
                gbuf_q[gcnt_q] <= gin_data;
                if (load_done_s) begin
                    gload_q      <= 1'b0;
                    gcnt_q       <= '0;
                    gout_valid_q <= 1'b1;
                    gout_data_q  <= groute_s;
                end else begin
                    gcnt_q <= gcnt_q + OWW'(1);
                end
            end else if (gout_acc_s) begin
                if (band_end_s && last_row_s) begin
                    gout_valid_q <= 1'b0;
                    done_q       <= 1'b1;
                end else if (band_end_s) begin
                    gout_valid_q <= 1'b0;
                    gload_q      <= 1'b1;
                end else begin
                    gout_data_q  <= groute_s;
                end
            end
        end
    end

    assign busy       = busy_s;
    assign done       = done_q;
    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign gin_ready  = gin_ready_s;
    assign gout_valid = gout_valid_q;
    assign gout_data  = gout_data_q;

endmodule

// File: tb/tb_max_pool_stream_ctrl.sv
// Self-checking bench for max_pool_stream_ctrl (4x4 map, stride 2): vector table plus corner sequences.
module tb_max_pool_stream_ctrl;

    typedef struct packed {
        logic [15:0][15:0] pix;
        logic [3:0][15:0]  gin;
        logic [3:0][15:0]  exp_out;
        logic [3:0][1:0]   exp_idx;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, start, mode, in_valid, out_ready, gin_valid, gout_ready;
    logic signed [15:0] in_data, gin_data;
    logic busy, done, in_ready, out_valid, gin_ready, gout_valid;
    logic signed [15:0] out_data, gout_data;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int exp_out_q[$];
    int exp_gout_q[$];
    logic bp_en = 1'b0;
    vec_t vecs[4];

    max_pool_stream_ctrl #(.WIDTH(16), .STRIDE(2), .IN_W(4), .IN_H(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .gin_valid(gin_valid), .gin_ready(gin_ready), .gin_data(gin_data),
        .gout_valid(gout_valid), .gout_ready(gout_ready), .gout_data(gout_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: pop expectations on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_out_q.size() == 0) begin
                total++; bad++;
                $display("FAIL out_extra: got %0d want none", int'(out_data));
            end else begin
                chk("out_data", int'(out_data), exp_out_q.pop_front());
            end
        end
        if (rst_n && gout_valid && gout_ready) begin
            if (exp_gout_q.size() == 0) begin
                total++; bad++;
                $display("FAIL gout_extra: got %0d want none", int'(gout_data));
            end else begin
                chk("gout_data", int'(gout_data), exp_gout_q.pop_front());
            end
        end
        if (done) done_cnt++;
    end

    always @(posedge clk) begin
        #1;
        gout_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic vec_t mk_vec(input int p[16], input int g[4], input int o[4], input int x[4]);
        vec_t v;
        for (int i = 0; i < 16; i++) v.pix[i] = 16'(p[i]);
        for (int i = 0; i < 4; i++) begin
            v.gin[i]     = 16'(g[i]);
            v.exp_out[i] = 16'(o[i]);
            v.exp_idx[i] = 2'(x[i]);
        end
        return v;
    endfunction

    // Reference pooling: strict greater-than keeps the earliest position on ties.
    task automatic model(input int p[16], output int o[4], output int x[4]);
        for (int w = 0; w < 4; w++) begin
            int best, bi, rr, cc;
            best = p[(w / 2) * 8 + (w % 2) * 2];
            bi = 0;
            for (int k = 1; k < 4; k++) begin
                rr = (w / 2) * 2 + k / 2;
                cc = (w % 2) * 2 + k % 2;
                if (p[rr * 4 + cc] > best) begin
                    best = p[rr * 4 + cc];
                    bi = k;
                end
            end
            o[w] = best;
            x[w] = bi;
        end
    endtask

    task automatic pulse_start(input logic m);
        @(posedge clk); #1;
        start = 1'b1; mode = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_pix(input int v);
        int n = 0;
        in_data = 16'(v); in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin n++; @(negedge clk); end
        if (n >= 100) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_gin(input int v);
        int n = 0;
        gin_data = 16'(v); gin_valid = 1'b1;
        @(negedge clk);
        while (!gin_ready && n < 100) begin n++; @(negedge clk); end
        if (n >= 100) chk("gin_ready_timeout", 0, 1);
        @(posedge clk); #1;
        gin_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        int n = 0;
        while (done_cnt == d0 && n < 200) begin n++; @(negedge clk); end
        repeat (3) @(negedge clk);
        chk({nm, "_done_count"}, done_cnt - d0, 1);
        chk({nm, "_busy_after"}, int'(busy), 0);
        chk({nm, "_out_left"}, exp_out_q.size(), 0);
        chk({nm, "_gout_left"}, exp_gout_q.size(), 0);
    endtask

    task automatic run_fwd(input vec_t v, input string nm);
        int d0 = done_cnt;
        for (int i = 0; i < 4; i++) exp_out_q.push_back(int'($signed(v.exp_out[i])));
        pulse_start(1'b0);
        for (int i = 0; i < 16; i++) send_pix(int'($signed(v.pix[i])));
        wait_done(d0, nm);
    endtask

    task automatic run_bwd(input logic [3:0][15:0] g, input logic [3:0][1:0] x, input string nm);
        int d0 = done_cnt;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int w = (r / 2) * 2 + c / 2;
                int k = (r % 2) * 2 + c % 2;
                exp_gout_q.push_back((int'(x[w]) == k) ? int'($signed(g[w])) : 0);
            end
        end
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++) send_gin(int'($signed(g[i])));
        wait_done(d0, nm);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_in_ready"}, int'(in_ready), 0);
        chk({nm, "_out_valid"}, int'(out_valid), 0);
        chk({nm, "_out_data"}, int'(out_data), 0);
        chk({nm, "_gin_ready"}, int'(gin_ready), 0);
        chk({nm, "_gout_valid"}, int'(gout_valid), 0);
        chk({nm, "_gout_data"}, int'(gout_data), 0);
    endtask

    initial begin
        int p1[16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 5, 6};
        int g1[4]  = '{8, 4, 6, 3};
        int o1[4]  = '{6, 8, 9, 6};
        int x1[4]  = '{3, 3, 0, 3};
        int p2[16] = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
        int g2[4]  = '{-7, 11, 2, -1};
        int o2[4]  = '{5, 5, 5, 5};
        int x2[4]  = '{0, 0, 0, 0};
        int p3[16] = '{-3, -3, -3, -3, -1, -3, -3, -3, -3, -3, -3, -3, -3, -3, -3, -3};
        int g3[4]  = '{100, -200, 300, -400};
        int o3[4]  = '{-1, -3, -3, -3};
        int x3[4]  = '{2, 0, 0, 0};
        int p4[16];
        int g4[4];
        int o4[4];
        int x4[4];
        logic [3:0][15:0] g0;
        logic [3:0][1:0]  z0;
        int d0, n;

        for (int i = 0; i < 16; i++) p4[i] = int'($urandom_range(0, 200)) - 100;
        for (int i = 0; i < 4; i++) g4[i] = int'($urandom_range(0, 2000)) - 1000;
        model(p4, o4, x4);
        vecs[0] = mk_vec(p1, g1, o1, x1);
        vecs[1] = mk_vec(p2, g2, o2, x2);
        vecs[2] = mk_vec(p3, g3, o3, x3);
        vecs[3] = mk_vec(p4, g4, o4, x4);
        for (int i = 0; i < 4; i++) begin
            g0[i] = 16'(i + 1);
            z0[i] = 2'd0;
        end

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; gin_valid = 1'b0; gin_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Backward with no forward history routes to each window's top-left.
        run_bwd(g0, z0, "bwd_fresh");

        for (int t = 0; t < 4; t++) begin
            run_fwd(vecs[t], $sformatf("fwd%0d", t));
            bp_en = (t == 3);
            run_bwd(vecs[t].gin, vecs[t].exp_idx, $sformatf("bwd%0d", t));
            bp_en = 1'b0;
        end

        // Backpressure on the first pooled word: it must hold and stall the pixel input.
        d0 = done_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_out_q.push_back(int'($signed(vecs[0].exp_out[i])));
        fork
            begin
                pulse_start(1'b0);
                for (int i = 0; i < 16; i++) send_pix(int'($signed(vecs[0].pix[i])));
            end
            begin
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 100) begin n++; @(negedge clk); end
                chk("stall_seen", int'(out_valid), 1);
                for (int j = 0; j < 3; j++) begin
                    chk("stall_out_data", int'(out_data), 6);
                    chk("stall_in_ready", int'(in_ready), 0);
                    @(negedge clk);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_done(d0, "stall");

        // Reset in the middle of a forward pass aborts it silently.
        d0 = done_cnt;
        pulse_start(1'b0);
        for (int i = 0; i < 5; i++) send_pix(int'($signed(vecs[0].pix[i])));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);

        // The argmax memory was cleared by that reset.
        run_bwd(g0, z0, "bwd_after_rst");
        run_fwd(vecs[0], "fwd_again");
        run_bwd(vecs[0].gin, vecs[0].exp_idx, "bwd_again");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
